// File: rtl/width_change_if.sv
// Signal bundle between the width-change controller and the PHY-side logic that requests width changes.
// The slave modport is the controller's view; the master modport is the requester's view.
interface width_change_if;
  logic       PLL_Locked;
  logic       Width_Req;
  logic [5:0] Width_Req_Val;
  logic [5:0] DataBusWidth;
  logic [7:0] Div_Ratio;
  logic       Clk_Gate_En;
  logic       PhyStatus;
  logic       Width_Ack;
  logic       Width_Err;
  logic       Busy;

  modport slave (
    input  PLL_Locked, Width_Req, Width_Req_Val,
    output DataBusWidth, Div_Ratio, Clk_Gate_En, PhyStatus, Width_Ack, Width_Err, Busy
  );

  modport master (
    output PLL_Locked, Width_Req, Width_Req_Val,
    input  DataBusWidth, Div_Ratio, Clk_Gate_En, PhyStatus, Width_Ack, Width_Err, Busy
  );
endinterface

// File: rtl/width_change_ctrl.sv
// Data-bus width change sequencer: waits for PLL lock, then gates PCLK, updates the divider,
// settles, and ungates PCLK. All outputs are registered.
module width_change_ctrl #(
  parameter int LOCK_CYCLES   = 64,
  parameter int GATE_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 16
) (
  input logic           Ref_Clk,
  input logic           rst,
  width_change_if.slave wc
);

  localparam int LOCK_W    = $clog2(LOCK_CYCLES + 1);
  localparam int PHASE_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);

  localparam logic [LOCK_W-1:0]  LOCK_LAST   = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [PHASE_W-1:0] GATE_LAST   = PHASE_W'(GATE_CYCLES - 1);
  localparam logic [PHASE_W-1:0] SETTLE_LAST = PHASE_W'(SETTLE_CYCLES - 1);
  localparam logic [5:0]         RST_WIDTH   = 6'd8;
  localparam logic [7:0]         RST_DIV     = 8'd10;

  typedef enum logic [2:0] {
    S_WAIT_LOCK,
    S_IDLE,
    S_GATE,
    S_UPDATE,
    S_SETTLE,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [PHASE_W-1:0] phase_cnt_q, phase_cnt_d;
  logic [5:0]         req_width_q, req_width_d;
  logic [5:0]         width_q, width_d;
  logic [7:0]         div_q, div_d;
  logic               gate_en_q, gate_en_d;
  logic               phy_status_q, phy_status_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               same_width_ack;

  function automatic logic legal_width(input logic [5:0] w);
    case (w)
      6'd8, 6'd16, 6'd32: legal_width = 1'b1;
      default:            legal_width = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] div_for(input logic [5:0] w);
    case (w)
      6'd8:    div_for = 8'd10;
      6'd16:   div_for = 8'd20;
      6'd32:   div_for = 8'd40;
      default: div_for = RST_DIV;
    endcase
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can leave one unassigned (no latches).
    state_d        = state_q;
    lock_cnt_d     = lock_cnt_q;
    phase_cnt_d    = phase_cnt_q;
    req_width_d    = req_width_q;
    width_d        = width_q;
    div_d          = div_q;
    err_d          = 1'b0;
    same_width_ack = 1'b0;

    case (state_q)
      S_WAIT_LOCK: begin
        if (!wc.PLL_Locked) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q >= LOCK_LAST) begin
          state_d    = S_IDLE;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
      end

      S_IDLE: begin
        // Lock loss wins over a simultaneous request, which is then dropped silently.
        if (!wc.PLL_Locked) begin
          state_d = S_WAIT_LOCK;
        end else if (wc.Width_Req) begin
          if (!legal_width(wc.Width_Req_Val)) begin
            err_d = 1'b1;
          end else if (wc.Width_Req_Val == width_q) begin
            same_width_ack = 1'b1;
          end else begin
            req_width_d = wc.Width_Req_Val;
            state_d     = S_GATE;
          end
        end
      end

      S_GATE: begin
        if (!wc.PLL_Locked) begin
          err_d   = 1'b1;
          state_d = S_WAIT_LOCK;
        end else if (phase_cnt_q >= GATE_LAST) begin
          state_d = S_UPDATE;
        end else begin
          phase_cnt_d = phase_cnt_q + PHASE_W'(1);
        end
      end

      S_UPDATE: begin
        // The divider is committed even if lock drops in this same cycle.
        width_d = req_width_q;
        div_d   = div_for(req_width_q);
        if (!wc.PLL_Locked) begin
          err_d   = 1'b1;
          state_d = S_WAIT_LOCK;
        end else begin
          state_d = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (!wc.PLL_Locked) begin
          err_d   = 1'b1;
          state_d = S_WAIT_LOCK;
        end else if (phase_cnt_q >= SETTLE_LAST) begin
          state_d = S_DONE;
        end else begin
          phase_cnt_d = phase_cnt_q + PHASE_W'(1);
        end
      end

      S_DONE: begin
        state_d = wc.PLL_Locked ? S_IDLE : S_WAIT_LOCK;
      end

      default: state_d = S_WAIT_LOCK;
    endcase

    if (state_d != state_q) begin
      phase_cnt_d = '0;
    end
    if (state_d != S_WAIT_LOCK) begin
      lock_cnt_d = '0;
    end

    // Outputs are decoded from the next state so the registered value lines up with the state.
    gate_en_d    = (state_d == S_IDLE) || (state_d == S_DONE);
    phy_status_d = (state_d == S_WAIT_LOCK) || (state_d == S_DONE) || same_width_ack;
    ack_d        = (state_d == S_DONE) || same_width_ack;
    busy_d       = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge Ref_Clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_WAIT_LOCK;
      lock_cnt_q   <= '0;
      phase_cnt_q  <= '0;
      req_width_q  <= RST_WIDTH;
      width_q      <= RST_WIDTH;
      div_q        <= RST_DIV;
      gate_en_q    <= 1'b0;
      phy_status_q <= 1'b1;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      phase_cnt_q  <= phase_cnt_d;
      req_width_q  <= req_width_d;
      width_q      <= width_d;
      div_q        <= div_d;
      gate_en_q    <= gate_en_d;
      phy_status_q <= phy_status_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign wc.DataBusWidth = width_q;
  assign wc.Div_Ratio    = div_q;
  assign wc.Clk_Gate_En  = gate_en_q;
  assign wc.PhyStatus    = phy_status_q;
  assign wc.Width_Ack    = ack_q;
  assign wc.Width_Err    = err_q;
  assign wc.Busy         = busy_q;

endmodule
